bram_arbiter_2p: RTL and testbench

// - Shares one single-port byte-enable BRAM between the fetch port (imem, read-only) and the

---
 rtl/bram_arb_pkg.sv | 17 +
 rtl/bram_arb_tag_pipe.sv | 45 ++++
 rtl/bram_arbiter_2p.sv | 133 +++++++++++++
 tb/tb_bram_arbiter_2p.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: request source, read tag, lane count.
package bram_arb_pkg;

  localparam int unsigned DEF_XLEN   = 32;
  localparam int unsigned BYTE_LANES = DEF_XLEN / 8;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_e;

  typedef struct packed {
    logic vld;
    src_e src;
  } rd_tag_t;

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Read-tag shift register matching the BRAM read latency.
// A fetch flush clears every IMEM tag as it moves and masks an IMEM tag
// leaving the last stage in the same cycle; the incoming tag is never cleared.
module bram_arb_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  input  logic    flush_imem,
  output logic    head_vld,
  output rd_tag_t tail
);

  rd_tag_t stage [STAGES];

  // Shift tags one stage per cycle, dropping IMEM tags on a flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
        if (flush_imem && stage[i-1].src == SRC_IMEM) begin
          stage[i].vld <= 1'b0;
        end
      end
    end
  end

  // Last stage drives the rvalids; a flush suppresses an IMEM return in its own cycle
  always_comb begin
    head_vld = stage[0].vld;
    tail     = stage[STAGES-1];
    if (flush_imem && stage[STAGES-1].src == SRC_IMEM) begin
      tail.vld = 1'b0;
    end
  end

endmodule

// File: rtl/bram_arbiter_2p.sv
// Shares one single-port byte-enable BRAM between the fetch (imem) and
// load/store (dmem) ports, one access per cycle, with tagged read return.
// Build option: define BRAM_ARB_RR_EN for round-robin arbitration; otherwise
// dmem has fixed priority over imem.
module bram_arbiter_2p
  import bram_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RD_LAT = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_req,
  input  logic [AW-1:0]         imem_addr,
  input  logic                  imem_flush,
  output logic                  imem_gnt,
  output logic                  imem_rvalid,
  output logic [XLEN-1:0]       imem_rdata,
  input  logic                  dmem_req,
  input  logic                  dmem_we,
  input  logic [AW-1:0]         dmem_addr,
  input  logic [XLEN-1:0]       dmem_wdata,
  input  logic [BYTE_LANES-1:0] dmem_byte_we,
  output logic                  dmem_gnt,
  output logic                  dmem_rvalid,
  output logic [XLEN-1:0]       dmem_rdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [AW-1:0]         bram_addr,
  output logic [XLEN-1:0]       bram_wdata,
  output logic [BYTE_LANES-1:0] bram_byte_we,
  input  logic [XLEN-1:0]       bram_rdata
);

  logic          imem_win;
  logic          dmem_win;
  logic [AW-1:0] addr_q;
  logic          tag_head_vld;
  rd_tag_t       tag_in;
  rd_tag_t       tag_tail;

`ifdef BRAM_ARB_RR_EN
  src_e last_src;

  // Round-robin: on contention the port that lost last time wins
  always_comb begin
    dmem_win = 1'b0;
    imem_win = 1'b0;
    if (rst_n) begin
      if (dmem_req && imem_req) begin
        dmem_win = (last_src == SRC_IMEM);
        imem_win = (last_src == SRC_DMEM);
      end else begin
        dmem_win = dmem_req;
        imem_win = imem_req;
      end
    end
  end

  // Last-winner pointer moves only on contended grants
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_src <= SRC_IMEM;
    end else if (dmem_req && imem_req) begin
      last_src <= dmem_win ? SRC_DMEM : SRC_IMEM;
    end
  end
`else
  // Fixed priority: dmem always beats imem
  always_comb begin
    dmem_win = rst_n && dmem_req;
    imem_win = rst_n && imem_req && !dmem_req;
  end
`endif

  // Drive the BRAM port from the winner; idle cycles keep the address and never write
  always_comb begin
    imem_gnt     = imem_win;
    dmem_gnt     = dmem_win;
    bram_addr    = addr_q;
    bram_we      = 1'b0;
    bram_byte_we = '0;
    bram_wdata   = dmem_wdata;
    if (dmem_win) begin
      bram_addr = dmem_addr;
      bram_we   = dmem_we;
      if (dmem_we) begin
        bram_byte_we = dmem_byte_we;
      end
    end else if (imem_win) begin
      bram_addr = imem_addr;
    end
    // Output register of the BRAM needs the enable in the cycle after a read grant
    bram_en = imem_win || dmem_win || tag_head_vld;
  end

  // Remember the last driven address so idle cycles hold it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= bram_addr;
    end
  end

  // Build the read tag for this cycle's grant; stores carry no tag
  always_comb begin
    tag_in.vld = imem_win || (dmem_win && !dmem_we);
    tag_in.src = dmem_win ? SRC_DMEM : SRC_IMEM;
  end

  bram_arb_tag_pipe #(
    .STAGES(RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .tag_in     (tag_in),
    .flush_imem (imem_flush),
    .head_vld   (tag_head_vld),
    .tail       (tag_tail)
  );

  // Route returning data to its requester; rvalid alone qualifies rdata
  always_comb begin
    imem_rvalid = tag_tail.vld && (tag_tail.src == SRC_IMEM);
    dmem_rvalid = tag_tail.vld && (tag_tail.src == SRC_DMEM);
    imem_rdata  = bram_rdata;
    dmem_rdata  = bram_rdata;
  end

endmodule

// File: tb/tb_bram_arbiter_2p.sv
// Scoreboard bench for bram_arbiter_2p: stimulus pushes expected read returns,
// a negedge monitor pops and compares them when an rvalid appears.
// Honours BRAM_ARB_RR_EN for the arbitration expectations.
module tb_bram_arbiter_2p;

  localparam int unsigned AW = 12;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req, imem_flush, imem_gnt, imem_rvalid;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_byte_we;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata, bram_rdata;
  logic [3:0]    bram_byte_we;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  exp_t        sb[$];

  bram_arbiter_2p #(
    .DEPTH  (4096),
    .XLEN   (32),
    .RD_LAT (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_flush   (imem_flush),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_we (dmem_byte_we),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata),
    .bram_byte_we (bram_byte_we),
    .bram_rdata   (bram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage BRAM model: array register then output register, both gated by bram_en
  logic [31:0] mem [1024];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (bram_en === 1'b1) begin
      if (bram_we === 1'b1) begin
        for (int b = 0; b < 4; b++) begin
          if (bram_byte_we[b]) mem[bram_addr[11:2]][b*8 +: 8] <= bram_wdata[b*8 +: 8];
        end
      end
      ram_q      <= mem[bram_addr[11:2]];
      bram_rdata <= ram_q;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest expectation, on its due cycle
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (imem_rvalid === 1'b1 || dmem_rvalid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_rvalid", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rvalid_src", {30'd0, imem_rvalid, dmem_rvalid}, e.is_d ? 32'd1 : 32'd2);
          chk("rdata", e.is_d ? dmem_rdata : imem_rdata, e.data);
          chk("rvalid_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_missing", {30'd0, imem_rvalid, dmem_rvalid}, e.is_d ? 32'd1 : 32'd2);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic gnt_chk(input string name, input bit ei, input bit ed);
    @(negedge clk);
    chk({name, "_imem_gnt"}, {31'd0, imem_gnt}, {31'd0, ei});
    chk({name, "_dmem_gnt"}, {31'd0, dmem_gnt}, {31'd0, ed});
  endtask

  // Both ports request; winner first, loser on the following cycle
  task automatic contend(input logic [AW-1:0] da, input logic [31:0] dd,
                         input logic [AW-1:0] ia, input logic [31:0] id, input bit dfirst);
    nxt();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = da;
    imem_req = 1'b1; imem_addr = ia;
    gnt_chk("contend_first", !dfirst, dfirst);
    if (dfirst) push(1'b1, dd); else push(1'b0, id);
    nxt();
    if (dfirst) dmem_req = 1'b0; else imem_req = 1'b0;
    gnt_chk("contend_second", dfirst, !dfirst);
    if (dfirst) push(1'b0, id); else push(1'b1, dd);
    nxt();
    imem_req = 1'b0; dmem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_i, n_d;
    bit          prev_d, have_prev;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;  // 0x010
    mem[8]  = 32'h0BADF00D;  // 0x020
    mem[12] = 32'h12345678;  // 0x030
    mem[16] = 32'hAAAAAAAA;  // 0x040
    mem[17] = 32'h0F0F0F0F;  // 0x044
    mem[18] = 32'hCAFEBABE;  // 0x048

    rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0; imem_flush = 1'b0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_byte_we = '0;

    // Reset: grants and writes forced off even with requests present
    nxt(); nxt();
    imem_req = 1'b1; dmem_req = 1'b1; dmem_we = 1'b1; dmem_byte_we = 4'hF;
    gnt_chk("reset", 1'b0, 1'b0);
    chk("reset_bram_we", {31'd0, bram_we}, 32'd0);
    chk("reset_rvalids", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
    nxt();
    rst_n = 1'b1; imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; dmem_byte_we = '0;

    // Solo imem read of 0x010
    nxt();
    imem_req = 1'b1; imem_addr = 12'h010;
    gnt_chk("solo", 1'b1, 1'b0);
    chk("solo_en0", {31'd0, bram_en}, 32'd1);
    chk("solo_addr", {20'd0, bram_addr}, 32'h010);
    push(1'b0, 32'hDEADBEEF);
    nxt();
    imem_req = 1'b0;
    @(negedge clk);
    chk("solo_en1", {31'd0, bram_en}, 32'd1);
    nxt();
    @(negedge clk);
    chk("idle_en", {31'd0, bram_en}, 32'd0);
    chk("idle_addr_hold", {20'd0, bram_addr}, 32'h010);
    chk("idle_we", {27'd0, bram_we, bram_byte_we}, 32'd0);

    // Contention: after reset both modes give dmem first
    contend(12'h020, 32'h0BADF00D, 12'h030, 32'h12345678, 1'b1);
`ifdef BRAM_ARB_RR_EN
    contend(12'h044, 32'h0F0F0F0F, 12'h048, 32'hCAFEBABE, 1'b0);
`else
    contend(12'h044, 32'h0F0F0F0F, 12'h048, 32'hCAFEBABE, 1'b1);
`endif

    // Partial store into lane 2, then load back
    nxt();
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 12'h040;
    dmem_wdata = 32'h11223344; dmem_byte_we = 4'b0100;
    gnt_chk("store", 1'b0, 1'b1);
    chk("store_we", {31'd0, bram_we}, 32'd1);
    chk("store_byte_we", {28'd0, bram_byte_we}, 32'h4);
    chk("store_wdata", bram_wdata, 32'h11223344);
    nxt();
    dmem_we = 1'b0; dmem_byte_we = '0;
    gnt_chk("load_after_store", 1'b0, 1'b1);
    push(1'b1, 32'hAA22AAAA);
    // Store with no lanes: granted, changes nothing
    nxt();
    dmem_we = 1'b1; dmem_wdata = 32'hFFFFFFFF; dmem_byte_we = 4'b0000;
    gnt_chk("store_nolane", 1'b0, 1'b1);
    chk("store_nolane_byte_we", {28'd0, bram_byte_we}, 32'd0);
    nxt();
    dmem_we = 1'b0;
    gnt_chk("load_after_nolane", 1'b0, 1'b1);
    push(1'b1, 32'hAA22AAAA);
    nxt();
    dmem_req = 1'b0;

    // Flush kills two in-flight fetches; a dmem load on the flush cycle returns
    nxt();
    imem_req = 1'b1; imem_addr = 12'h010;
    gnt_chk("flush_rd0", 1'b1, 1'b0);
    nxt();
    imem_addr = 12'h030;
    gnt_chk("flush_rd1", 1'b1, 1'b0);
    nxt();
    imem_req = 1'b0; imem_flush = 1'b1;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 12'h020;
    gnt_chk("flush_dmem", 1'b0, 1'b1);
    push(1'b1, 32'h0BADF00D);
    nxt();
    imem_flush = 1'b0; dmem_req = 1'b0;
    // Fetch granted in a flush cycle survives
    nxt();
    imem_req = 1'b1; imem_addr = 12'h048; imem_flush = 1'b1;
    gnt_chk("flush_same_cycle", 1'b1, 1'b0);
    push(1'b0, 32'hCAFEBABE);
    nxt();
    imem_req = 1'b0; imem_flush = 1'b0;
    nxt(); nxt();

    // Reset one cycle after a fetch grant drops the read
    nxt();
    imem_req = 1'b1; imem_addr = 12'h010;
    gnt_chk("prereset", 1'b1, 1'b0);
    nxt();
    rst_n = 1'b0; dmem_req = 1'b1;
    gnt_chk("midreset", 1'b0, 1'b0);
    nxt();
    rst_n = 1'b1; imem_req = 1'b0; dmem_req = 1'b0;
    nxt(); nxt(); nxt();
    imem_req = 1'b1; imem_addr = 12'h030;
    gnt_chk("postreset", 1'b1, 1'b0);
    push(1'b0, 32'h12345678);
    nxt();
    imem_req = 1'b0;
    nxt(); nxt();

    // Continuous contention for 1000 cycles
    n_i = 0; n_d = 0; have_prev = 1'b0; prev_d = 1'b0;
    nxt();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 12'h020;
    imem_req = 1'b1; imem_addr = 12'h030;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("one_gnt", {30'd0, imem_gnt, dmem_gnt}, dmem_gnt ? 32'd1 : 32'd2);
      if (dmem_gnt) begin n_d++; push(1'b1, 32'h0BADF00D); end
      if (imem_gnt) begin n_i++; push(1'b0, 32'h12345678); end
`ifdef BRAM_ARB_RR_EN
      if (have_prev) chk("alternate", {31'd0, dmem_gnt}, {31'd0, !prev_d});
`endif
      prev_d = dmem_gnt; have_prev = 1'b1;
      nxt();
    end
    dmem_req = 1'b0; imem_req = 1'b0;
`ifdef BRAM_ARB_RR_EN
    chk("stress_imem_grants", n_i, 32'd500);
    chk("stress_dmem_grants", n_d, 32'd500);
`else
    chk("stress_imem_grants", n_i, 32'd0);
    chk("stress_dmem_grants", n_d, 32'd1000);
`endif

    repeat (5) nxt();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
